// File: rtl/lock_sequencer.sv
// Keypad door-lock sequencer: entry, verification, unlock hold, door tracking,
// failure lockout and held-open mode, all sharing one down-timer.
module lock_sequencer #(
  parameter int ENTRY_TIMEOUT  = 200,
  parameter int VERIFY_TIMEOUT = 16,
  parameter int UNLOCK_HOLD    = 500,
  parameter int MAX_FAIL       = 3,
  parameter int LOCKOUT_CYCLES = 1000,
  parameter int LONG_PRESS     = 8
) (
  input  logic       clk_i,
  input  logic       reset_n_i,
  input  logic       key_valid_i,
  input  logic       star_i,
  input  logic       hash_i,
  input  logic       correct_i,
  input  logic       wrong_i,
  input  logic       open_button_i,
  input  logic       close_sensor_i,
  output logic       unlock_o,
  output logic       alert_en_o,
  output logic       entry_clear_o,
  output logic       hold_open_o,
  output logic [2:0] fail_cnt_o,
  output logic [2:0] state_o
);

  localparam int M1 = (ENTRY_TIMEOUT > VERIFY_TIMEOUT) ? ENTRY_TIMEOUT : VERIFY_TIMEOUT;
  localparam int M2 = (M1 > UNLOCK_HOLD) ? M1 : UNLOCK_HOLD;
  localparam int M3 = (M2 > LOCKOUT_CYCLES) ? M2 : LOCKOUT_CYCLES;
  localparam int TW = $clog2(M3 + 1);
  localparam int LW = $clog2(LONG_PRESS + 1);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_ENTRY    = 3'd1,
    S_VERIFY   = 3'd2,
    S_UNLOCKED = 3'd3,
    S_OPENED   = 3'd4,
    S_LOCKOUT  = 3'd5,
    S_HELD     = 3'd6
  } state_t;

  state_t          state_q, state_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic [LW-1:0]   lp_cnt_q, lp_cnt_d;
  logic [2:0]      fail_q, fail_d;
  logic            armed_q, armed_d;
  logic            clr_q, clr_d;
  logic            open_prev_q;
  logic            close_prev_q;
  logic            unlock_q;
  logic            alert_q;
  logic            hold_q;

  logic            open_rise;
  logic            close_rise;
  logic            close_fall;
  logic            timer_expire;
  logic            lp_done;
  logic [2:0]      fail_inc;

  function automatic logic unlock_of(input state_t s);
    return (s == S_UNLOCKED) || (s == S_OPENED) || (s == S_HELD);
  endfunction

  assign open_rise    = open_button_i & ~open_prev_q;
  assign close_rise   = close_sensor_i & ~close_prev_q;
  assign close_fall   = ~close_sensor_i & close_prev_q;
  // The cycle that would take the timer to zero is the cycle the timeout fires.
  assign timer_expire = (timer_q <= TW'(1));
  assign fail_inc     = (fail_q >= 3'(MAX_FAIL)) ? 3'(MAX_FAIL) : fail_q + 3'd1;

  always_comb begin
    lp_done  = 1'b0;
    lp_cnt_d = '0;
    if (open_button_i) begin
      if (lp_cnt_q == LW'(LONG_PRESS - 1)) begin
        lp_done = 1'b1;
      end else begin
        lp_cnt_d = lp_cnt_q + 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    timer_d = (timer_q != '0) ? timer_q - 1'b1 : '0;
    fail_d  = fail_q;
    armed_d = armed_q;
    clr_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (open_rise) begin
          state_d = S_UNLOCKED;
          timer_d = TW'(UNLOCK_HOLD);
        end else if (key_valid_i) begin
          state_d = S_ENTRY;
          timer_d = TW'(ENTRY_TIMEOUT);
        end
      end
      S_ENTRY: begin
        if (open_rise) begin
          state_d = S_UNLOCKED;
          timer_d = TW'(UNLOCK_HOLD);
          clr_d   = 1'b1;
        end else if (hash_i) begin
          state_d = S_IDLE;
          clr_d   = 1'b1;
        end else if (star_i) begin
          state_d = S_VERIFY;
          timer_d = TW'(VERIFY_TIMEOUT);
        end else if (key_valid_i) begin
          timer_d = TW'(ENTRY_TIMEOUT);
        end else if (timer_expire) begin
          state_d = S_IDLE;
          clr_d   = 1'b1;
        end
      end
      S_VERIFY: begin
        // A simultaneous CORRECT and WRONG is treated as a failure.
        if (correct_i && !wrong_i) begin
          state_d = S_UNLOCKED;
          timer_d = TW'(UNLOCK_HOLD);
          fail_d  = 3'd0;
          clr_d   = 1'b1;
        end else if (wrong_i || timer_expire) begin
          fail_d = fail_inc;
          clr_d  = 1'b1;
          if (fail_inc == 3'(MAX_FAIL)) begin
            state_d = S_LOCKOUT;
            timer_d = TW'(LOCKOUT_CYCLES);
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      S_UNLOCKED: begin
        if (lp_done) begin
          state_d = S_HELD;
          armed_d = 1'b0;
        end else if (close_fall) begin
          state_d = S_OPENED;
        end else if (timer_expire) begin
          state_d = S_IDLE;
        end
      end
      S_OPENED: begin
        if (lp_done) begin
          state_d = S_HELD;
          armed_d = 1'b0;
        end else if (close_rise) begin
          state_d = S_IDLE;
        end
      end
      S_HELD: begin
        // A press still held from entering HELD must be released before it can exit.
        if (!open_button_i) begin
          armed_d = 1'b1;
        end
        if (lp_done && armed_q) begin
          state_d = S_IDLE;
        end
      end
      S_LOCKOUT: begin
        if (open_rise) begin
          state_d = S_UNLOCKED;
          timer_d = TW'(UNLOCK_HOLD);
          fail_d  = 3'd0;
        end else if (timer_expire) begin
          state_d = S_IDLE;
          fail_d  = 3'd0;
        end
      end
      default: begin
        state_d = S_IDLE;
        timer_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      state_q      <= S_IDLE;
      timer_q      <= '0;
      lp_cnt_q     <= '0;
      fail_q       <= 3'd0;
      armed_q      <= 1'b0;
      clr_q        <= 1'b0;
      open_prev_q  <= 1'b0;
      close_prev_q <= 1'b1;
      unlock_q     <= 1'b0;
      alert_q      <= 1'b0;
      hold_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      timer_q      <= timer_d;
      lp_cnt_q     <= lp_cnt_d;
      fail_q       <= fail_d;
      armed_q      <= armed_d;
      clr_q        <= clr_d;
      open_prev_q  <= open_button_i;
      close_prev_q <= close_sensor_i;
      unlock_q     <= unlock_of(state_d);
      alert_q      <= (state_d == S_LOCKOUT);
      hold_q       <= (state_d == S_HELD);
    end
  end

  assign unlock_o      = unlock_q;
  assign alert_en_o    = alert_q;
  assign entry_clear_o = clr_q;
  assign hold_open_o   = hold_q;
  assign fail_cnt_o    = fail_q;
  assign state_o       = state_q;

endmodule
